mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the 5-stage MIPS pipeline; it sits between the EX/MEM register and the MEM/WB register. It turns ALU_Out_M/Write_Data_M into a handshaked data-memory transaction with byte enables, and returns the aligned, extended load result as Mem_Read_Data_M. While the access is outstanding it holds the pipeline with Stall_M.

## Interface
- No parameters; data/address width fixed at 32.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- Mem_Read_M  in  1  load in MEM stage.
- Mem_Write_M  in  1  store in MEM stage; never set together with Mem_Read_M.
- Mem_Size_M  in  2  00 byte, 01 half, 10 word, 11 illegal.
- Mem_Unsigned_M  in  1  zero-extend loads (lbu/lhu) when 1, else sign-extend.
- ALU_Out_M  in  32  effective byte address.
- Write_Data_M  in  32  store data (low bits used for byte/half).
- Mem_Read_Data_M  out  32  load result to MEM/WB.
- Stall_M  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB input stable.
- Misalign_M  out  1  one-cycle exception flag.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write when 1.
- dmem_addr  out  32  word address, bits [1:0] = 00.
- dmem_be  out  4  byte enables (bit i = byte lane i).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  memory accepted/completed the request this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready=1 on reads.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: op = Mem_Read_M|Mem_Write_M. Misaligned = half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - op and misaligned: Misalign_M=1 (combinational), Stall_M=0, no request, Mem_Read_Data_M=0, stay IDLE.
  - op and aligned: Stall_M=1; register dmem_addr/we/be/wdata, the extraction controls (addr[1:0], size, unsigned), dmem_req←1; go REQ.
  - no op: Stall_M=0, Mem_Read_Data_M=0.
- REQ: Stall_M=1; dmem_req and all bus outputs held constant. On dmem_ready=1: load result (extracted from dmem_rdata) captured into data register, dmem_req←0, go DONE.
- DONE: Stall_M=0, Mem_Read_Data_M = data register (0 for stores); go IDLE unconditionally. MEM/WB samples the instruction at the end of this cycle.
- Byte enables: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
- Store data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Load extraction: lane = rdata>>(8·addr[1:0]); byte/half take low 8/16 bits, sign- or zero-extend per Mem_Unsigned_M.
- dmem_ready ignored outside REQ.

## Timing
- Reset (rst=0, async): state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, data register 0. Hence Stall_M=0, Misalign_M=0, Mem_Read_Data_M=0 unless a MEM op is presented. Reset during REQ drops dmem_req immediately; the transaction is abandoned.
- Memory op entering MEM at cycle 0, dmem_ready first high at cycle k≥1: Stall_M high for cycles 0..k, low in cycle k+1 (DONE), pipeline advances at end of k+1. Minimum: 2 stall cycles.
- dmem_req high from cycle 1 through cycle k inclusive; exactly one request per instruction.
- Misaligned ops and non-memory instructions: zero stall cycles.
- Back-to-back memory ops: the second enters IDLE the cycle after DONE; no bubble beyond its own stalls.

## Structure
- Shared package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum.
- Sub-module lsu_align (combinational): byte-enable/store-data steering and load extraction/extension. It is used once for the store path and once for the load path.

## Test plan
- sw: addr 0x100, data 0xDEADBEEF, ready at k=1 -> be 1111, addr 0x100, wdata 0xDEADBEEF, Stall_M high 2 cycles, one req.
- lb: addr 0x203, rdata 0x80FF_0000, signed then unsigned -> Mem_Read_Data_M 0xFFFFFF80 / 0x00000080 in DONE.
- sh: addr 0x12, data 0x0000ABCD -> addr 0x10, be 1100, wdata 0xABCDABCD.
- lw: addr 0x106 -> Misalign_M=1 for one cycle, Stall_M=0, dmem_req never asserted.
- lhu: ready delayed to k=5 -> Stall_M high cycles 0-5, bus outputs stable throughout, result in cycle 6.
- rst low while in REQ -> dmem_req=0 same cycle, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access sizes, FSM states,
// and the alignment rule used to raise Misalign_M.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Size 11 has no legal encoding, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mode gives byte enables and lane-replicated data,
// load mode shifts the addressed lane down and sign/zero-extends it.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic        is_load,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [3:0]  be
);

    logic [31:0] lane;
    logic [31:0] rep;
    logic [31:0] ext;

    always_comb begin
        lane = din >> {addr_lo, 3'b000};
        be   = 4'b1111;
        rep  = din;
        ext  = lane;
        case (size)
            SZ_BYTE: begin
                be  = 4'b0001 << addr_lo;
                rep = {4{din[7:0]}};
                ext = {{24{~uns & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                be  = addr_lo[1] ? 4'b1100 : 4'b0011;
                rep = {2{din[15:0]}};
                ext = {{16{~uns & lane[15]}}, lane[15:0]};
            end
            default: begin
                be  = 4'b1111;
                rep = din;
                ext = lane;
            end
        endcase
        dout = is_load ? ext : rep;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the EX/MEM operands into one handshaked
// data-memory transaction and stalls the pipeline until its result is ready.
module mem_stage_lsu
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_Read_M,
    input  logic        Mem_Write_M,
    input  logic [1:0]  Mem_Size_M,
    input  logic        Mem_Unsigned_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] Write_Data_M,
    output logic [31:0] Mem_Read_Data_M,
    output logic        Stall_M,
    output logic        Misalign_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  lsu_state_dbg
);

    // Handshake: dmem_req rises the cycle after an aligned op is seen and every
    // bus output stays frozen until the first cycle dmem_ready=1 while in REQ.
    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] data_q, data_d;

    logic        op;
    logic        bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [3:0]  ld_be_unused;

    assign op  = Mem_Read_M | Mem_Write_M;
    assign bad = is_misaligned(Mem_Size_M, ALU_Out_M[1:0]);

    lsu_align u_store (
        .size    (Mem_Size_M),
        .uns     (Mem_Unsigned_M),
        .addr_lo (ALU_Out_M[1:0]),
        .is_load (1'b0),
        .din     (Write_Data_M),
        .dout    (st_wdata),
        .be      (st_be)
    );

    // Extraction uses the controls captured at issue, not the live EX/MEM values.
    lsu_align u_load (
        .size    (size_q),
        .uns     (uns_q),
        .addr_lo (lane_q),
        .is_load (1'b1),
        .din     (dmem_rdata),
        .dout    (ld_data),
        .be      (ld_be_unused)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (op && !bad) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = Mem_Write_M;
                    addr_d  = {ALU_Out_M[31:2], 2'b00};
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    lane_d  = ALU_Out_M[1:0];
                    size_d  = Mem_Size_M;
                    uns_d   = Mem_Unsigned_M;
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    data_d  = we_q ? 32'h0 : ld_data;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            lane_q  <= 2'b00;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        Stall_M         = 1'b0;
        Misalign_M      = 1'b0;
        Mem_Read_Data_M = 32'h0;
        case (state_q)
            ST_IDLE: begin
                Stall_M    = op & ~bad;
                Misalign_M = op & bad;
            end
            ST_REQ:  Stall_M = 1'b1;
            ST_DONE: Mem_Read_Data_M = data_q;
            default: Stall_M = 1'b0;
        endcase
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign lsu_state_dbg = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, reset-in-REQ sequence and
// randomized ops checked against an arithmetic model of the access rules.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        Mem_Read_M;
    logic        Mem_Write_M;
    logic [1:0]  Mem_Size_M;
    logic        Mem_Unsigned_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] Write_Data_M;
    logic [31:0] Mem_Read_Data_M;
    logic        Stall_M;
    logic        Misalign_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [1:0]  lsu_state_dbg;

    mem_stage_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .Mem_Read_M      (Mem_Read_M),
        .Mem_Write_M     (Mem_Write_M),
        .Mem_Size_M      (Mem_Size_M),
        .Mem_Unsigned_M  (Mem_Unsigned_M),
        .ALU_Out_M       (ALU_Out_M),
        .Write_Data_M    (Write_Data_M),
        .Mem_Read_Data_M (Mem_Read_Data_M),
        .Stall_M         (Stall_M),
        .Misalign_M      (Misalign_M),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_ready      (dmem_ready),
        .dmem_rdata      (dmem_rdata),
        .lsu_state_dbg   (lsu_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdw;
        int          k;
        logic        mis;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eres;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%08h, expected 0x%08h", name, what, act, exp);
        end
    endtask

    // Reference: access width in bytes, offset in word, lanes covered, data replicated.
    function automatic void model(input logic rd, input logic wr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdw, output logic mis, output logic [31:0] eaddr,
                                  output logic [3:0] ebe, output logic [31:0] ewd, output logic [31:0] eres);
        int nb;
        int off;
        logic [31:0] val;
        logic [31:0] mask;
        off   = int'(addr % 4);
        nb    = (size == 2'd3) ? 0 : (1 << size);
        mis   = (rd || wr) && ((nb == 0) || ((off % ((nb == 0) ? 1 : nb)) != 0));
        eaddr = addr - 32'(off);
        ebe   = 4'(((1 << nb) - 1) << off);
        ewd   = 32'h0;
        if (nb != 0)
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        val = rdw >> (8 * off);
        if (nb == 1 || nb == 2) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            val  = val & mask;
            if (!uns && val[8*nb-1]) val = val | ~mask;
        end
        eres = rd ? val : 32'h0;
    endfunction

    // Driver: presents one MEM-stage instruction starting just after a rising edge,
    // plays the memory side with ready first high in cycle k, and returns after the
    // cycle in which the pipeline advances.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdw, input int k, input logic mis, input logic [31:0] eaddr,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eres);
        int   reqs;
        logic prev;
        Mem_Read_M     = rd;
        Mem_Write_M    = wr;
        Mem_Size_M     = size;
        Mem_Unsigned_M = uns;
        ALU_Out_M      = addr;
        Write_Data_M   = wd;
        dmem_ready     = 1'b0;
        dmem_rdata     = $urandom;
        if (!(rd || wr) || mis) begin
            @(negedge clk);
            chk(name, "misalign", 32'(Misalign_M), 32'(mis));
            chk(name, "stall", 32'(Stall_M), 32'h0);
            chk(name, "req", 32'(dmem_req), 32'h0);
            chk(name, "rdata_out", Mem_Read_Data_M, 32'h0);
            @(posedge clk);
            #1;
            return;
        end
        exp_q.push_back(eres);
        reqs = 0;
        prev = dmem_req;
        for (int c = 0; c <= k + 1; c++) begin
            dmem_ready = (c == k);
            dmem_rdata = (c == k) ? rdw : $urandom;
            @(negedge clk);
            if (dmem_req && !prev) reqs++;
            prev = dmem_req;
            chk(name, $sformatf("stall c%0d", c), 32'(Stall_M), (c <= k) ? 32'h1 : 32'h0);
            chk(name, $sformatf("req c%0d", c), 32'(dmem_req), (c >= 1 && c <= k) ? 32'h1 : 32'h0);
            chk(name, "misalign", 32'(Misalign_M), 32'h0);
            if (c >= 1 && c <= k) begin
                chk(name, "addr", dmem_addr, eaddr);
                chk(name, "be", 32'(dmem_be), 32'(ebe));
                chk(name, "we", 32'(dmem_we), 32'(wr));
                if (wr) chk(name, "wdata", dmem_wdata, ewd);
            end
            if (c == k + 1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard: expected queue empty", name);
                end else begin
                    chk(name, "result", Mem_Read_Data_M, exp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
        end
        dmem_ready = 1'b0;
        chk(name, "req_count", 32'(reqs), 32'h1);
    endtask

    task automatic idle_cycle();
        run_op("idle", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic        rd, wr, uns, mis;
        logic [1:0]  size;
        logic [31:0] addr, wd, rdw, eaddr, ewd, eres;
        logic [3:0]  ebe;
        int          k, sel;

        // rd, wr, size, uns, addr, wd, rdw, k, mis, eaddr, ebe, ewd, eres
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80FF0000, 1, 1'b0, 32'h200, 4'h8, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80FF0000, 1, 1'b0, 32'h200, 4'h8, 32'h0, 32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 32'h0, 1, 1'b0, 32'h10, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h106, 32'h0, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h87654321, 5, 1'b0, 32'h0, 4'hC, 32'h0, 32'h00008765};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h87654321, 2, 1'b0, 32'h0, 4'hC, 32'h0, 32'hFFFF8765};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h123456A5, 32'h0, 2, 1'b0, 32'h100, 4'h2, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h3, 32'h1234, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h106, 32'h0, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20C, 32'h0, 32'h01234567, 3, 1'b0, 32'h20C, 4'hF, 32'h0, 32'h01234567};
        vecs[12] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h1234FFFE, 1, 1'b0, 32'h0, 4'h3, 32'h0, 32'h0000FFFE};

        rst            = 1'b0;
        Mem_Read_M     = 1'b0;
        Mem_Write_M    = 1'b0;
        Mem_Size_M     = 2'd0;
        Mem_Unsigned_M = 1'b0;
        ALU_Out_M      = 32'h0;
        Write_Data_M   = 32'h0;
        dmem_ready     = 1'b0;
        dmem_rdata     = 32'h0;

        @(negedge clk);
        chk("reset", "state", 32'(lsu_state_dbg), 32'h0);
        chk("reset", "req", 32'(dmem_req), 32'h0);
        chk("reset", "we", 32'(dmem_we), 32'h0);
        chk("reset", "addr", dmem_addr, 32'h0);
        chk("reset", "be", 32'(dmem_be), 32'h0);
        chk("reset", "wdata", dmem_wdata, 32'h0);
        chk("reset", "stall", 32'(Stall_M), 32'h0);
        chk("reset", "misalign", 32'(Misalign_M), 32'h0);
        chk("reset", "rdata_out", Mem_Read_Data_M, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // directed table, mostly back-to-back
        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns,
                   vecs[i].addr, vecs[i].wd, vecs[i].rdw, vecs[i].k, vecs[i].mis,
                   vecs[i].eaddr, vecs[i].ebe, vecs[i].ewd, vecs[i].eres);
            if (i % 3 == 2) idle_cycle();
        end
        idle_cycle();

        // reset while a request is outstanding
        Mem_Read_M   = 1'b1;
        Mem_Write_M  = 1'b0;
        Mem_Size_M   = 2'd2;
        ALU_Out_M    = 32'h40;
        Write_Data_M = 32'h5555AAAA;
        dmem_ready   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_in_req", "req_before", 32'(dmem_req), 32'h1);
        #2;
        rst         = 1'b0;
        Mem_Read_M  = 1'b0;
        Mem_Write_M = 1'b0;
        #1;
        chk("rst_in_req", "req", 32'(dmem_req), 32'h0);
        chk("rst_in_req", "state", 32'(lsu_state_dbg), 32'h0);
        chk("rst_in_req", "stall", 32'(Stall_M), 32'h0);
        chk("rst_in_req", "addr", dmem_addr, 32'h0);
        chk("rst_in_req", "be", 32'(dmem_be), 32'h0);
        chk("rst_in_req", "wdata", dmem_wdata, 32'h0);
        chk("rst_in_req", "we", 32'(dmem_we), 32'h0);
        chk("rst_in_req", "rdata_out", Mem_Read_Data_M, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle();
        run_op("after_rst", 1'b1, 1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 32'h0000C300, 2,
               1'b0, 32'h40, 4'h2, 32'h0, 32'h000000C3);

        // randomized ops against the model
        for (int n = 0; n < 200; n++) begin
            sel  = $urandom_range(0, 9);
            rd   = (sel < 5);
            wr   = (sel >= 5 && sel < 9);
            size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom_range(0, 1));
            addr = $urandom & 32'h0000_0FFF;
            wd   = $urandom;
            rdw  = $urandom;
            k    = $urandom_range(1, 4);
            model(rd, wr, size, uns, addr, wd, rdw, mis, eaddr, ebe, ewd, eres);
            run_op($sformatf("rand%0d", n), rd, wr, size, uns, addr, wd, rdw, k, mis, eaddr, ebe, ewd, eres);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
